// File: rtl/keyboard_controller.sv
// PS/2 keyboard receiver: synchronizer, frame FSM, scan-code FIFO and a 4-word register window.
// Optional macro KEYBOARD_PARITY_CHECK_EN enables odd-parity checking of received frames.
module keyboard_controller #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_enable_in,
  output logic [31:0] data_out,
  output logic        valid_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

`ifdef KEYBOARD_PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction
`endif

  logic          clk_sync1_q, clk_sync2_q, clk_hist_q;
  logic          data_sync1_q, data_sync2_q, data_hist_q;
  logic          fall_s;
  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push_s, timeout_s, parity_fail_s;
  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [8:0]    count_ext_s;
  logic          empty_s, full_s, do_push_s, do_pop_s, overflow_set_s;
  logic          write_s, pop_req_s, clear_s, flush_s;
  logic [2:0]    flags_q;
  logic [31:0]   rd_data_d;
  logic          unused_s;

  // Two-flop synchronizers plus one history flop per PS/2 line; lines idle high.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      {clk_sync1_q, clk_sync2_q, clk_hist_q}    <= 3'b111;
      {data_sync1_q, data_sync2_q, data_hist_q} <= 3'b111;
    end else begin
      {clk_sync1_q, clk_sync2_q, clk_hist_q}    <= {ps2_clk_in, clk_sync1_q, clk_sync2_q};
      {data_sync1_q, data_sync2_q, data_hist_q} <= {ps2_data_in, data_sync1_q, data_sync2_q};
    end
  end

  assign fall_s = clk_hist_q & ~clk_sync2_q;

  // Frame FSM state registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 10'd0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Frame FSM next state; bits arrive LSB first so the start of the frame ends up in bit 0.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    to_cnt_d      = to_cnt_q;
    push_s        = 1'b0;
    timeout_s     = 1'b0;
    parity_fail_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s && !data_hist_q) begin
          state_d   = SHIFT;
          bit_cnt_d = 4'd0;
          to_cnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (fall_s) begin
          shift_d   = {data_hist_q, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = CHECK;
          end else begin
            state_d = SHIFT;
          end
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          timeout_s = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (shift_q[9]) begin
`ifdef KEYBOARD_PARITY_CHECK_EN
          if (odd_parity_ok(shift_q[8:0])) begin
            push_s = 1'b1;
          end else begin
            parity_fail_s = 1'b1;
          end
`else
          push_s = 1'b1;
`endif
        end else begin
          push_s = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign write_s   = |write_enable_in;
  assign pop_req_s = write_s && (addr_in[3:2] == 2'd2);
  assign clear_s   = write_s && (addr_in[3:2] == 2'd3) && data_in[0];
  assign flush_s   = write_s && (addr_in[3:2] == 2'd3) && data_in[1];

  assign empty_s        = (count_q == '0);
  assign full_s         = (count_q == CW'(DEPTH));
  assign do_pop_s       = pop_req_s && !empty_s;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push_s      = push_s && (!full_s || do_pop_s);
  assign overflow_set_s = push_s && full_s && !do_pop_s;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_in) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q[7:0];
    end
  end

  // FIFO pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_s) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags {frame_err, parity_err, overflow}; a same-cycle set beats the clear.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= (flags_q & ~{3{clear_s}}) | {timeout_s, parity_fail_s, overflow_set_s};
    end
  end

  assign count_ext_s = 9'(count_q);

  // Register read mux over the current state.
  always_comb begin
    rd_data_d = 32'd0;
    case (addr_in[3:2])
      2'd0: begin
        if (empty_s) begin
          rd_data_d = 32'd0;
        end else begin
          rd_data_d = {23'd0, 1'b1, mem_q[rd_ptr_q[AW-1:0]]};
        end
      end
      2'd1:    rd_data_d = {16'd0, count_ext_s[7:0], 5'd0, flags_q};
      default: rd_data_d = 32'd0;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_out <= 32'd0;
    end else begin
      data_out <= rd_data_d;
    end
  end

  assign valid_out = !empty_s;

  assign unused_s = &{1'b0, addr_in[31:4], addr_in[1:0], data_in[31:2], shift_q[8], count_ext_s[8]};

endmodule
